// File: rtl/interval_timer.sv
// interval_timer: tick-driven countdown with one-shot/periodic modes, hold, abort and expiry pulse; optional extend via TIMER_EXTEND_EN
module interval_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             sys_reset,
  input  logic [WIDTH-1:0] input_value,
  input  logic             mode,
  input  logic             start_timer,
  input  logic             enable,
  input  logic             hold,
  input  logic             abort,
`ifdef TIMER_EXTEND_EN
  input  logic             extend,
  input  logic [WIDTH-1:0] extend_value,
`endif
  output logic             expired,
  output logic             divider_reset,
  output logic             busy,
  output logic [WIDTH-1:0] remaining
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] count, reload, ext_count;
  logic mode_q, tick, ext_hit;
  assign tick = state == RUN && enable && !hold;
  assign busy = state == RUN;
  assign remaining = count;
`ifdef TIMER_EXTEND_EN
  logic [WIDTH:0] ext_sum;
  assign ext_sum = {1'b0, count} + {1'b0, extend_value} - {{WIDTH{1'b0}}, tick};
  // a nonzero extension always leaves a nonzero count, so it pre-empts any expiry
  assign ext_hit = state == RUN && extend && extend_value != '0;
  assign ext_count = ext_sum[WIDTH] ? '1 : ext_sum[WIDTH-1:0];
`else
  assign ext_hit = 1'b0;
  assign ext_count = count;
`endif
  // abort beats start beats extend/tick; pulses default low every cycle
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state <= IDLE;
      count <= '0;
      reload <= '0;
      mode_q <= 1'b0;
      expired <= 1'b0;
      divider_reset <= 1'b0;
    end else begin
      expired <= 1'b0;
      divider_reset <= 1'b0;
      if (abort) begin
        state <= IDLE;
        count <= '0;
      end else if (start_timer) begin
        count <= input_value;
        reload <= input_value;
        mode_q <= mode;
        divider_reset <= 1'b1;
        expired <= input_value == '0;
        state <= input_value == '0 ? IDLE : RUN;
      end else if (ext_hit) begin
        count <= ext_count;
      end else if (tick) begin
        if (count != WIDTH'(1)) begin
          count <= count - 1'b1;
        end else begin
          expired <= 1'b1;
          count <= mode_q ? reload : '0;
          state <= mode_q ? RUN : IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: scoreboard bench for interval_timer pulses plus direct count/busy checks
module tb_interval_timer;
  logic clk = 0, sys_reset = 1;
  logic [3:0] input_value = 0;
  logic [7:0] val8 = 0;
  logic mode = 0, start_timer = 0, start8 = 0, enable = 0, hold = 0, abort = 0;
  logic expired, divider_reset, busy, exp8, dr8, busy8;
  logic [3:0] remaining;
  logic [7:0] rem8;
`ifdef TIMER_EXTEND_EN
  logic ext = 0;
  logic [3:0] ext_val = 0;
`endif
  int checks = 0, failures = 0, pc = 0;
  typedef struct {int cyc; logic e; logic d;} ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) pc <= pc + 1;

  interval_timer #(.WIDTH(4)) u (
    .clk(clk), .sys_reset(sys_reset), .input_value(input_value), .mode(mode),
    .start_timer(start_timer), .enable(enable), .hold(hold), .abort(abort),
`ifdef TIMER_EXTEND_EN
    .extend(ext), .extend_value(ext_val),
`endif
    .expired(expired), .divider_reset(divider_reset), .busy(busy), .remaining(remaining));

  interval_timer #(.WIDTH(8)) u8 (
    .clk(clk), .sys_reset(sys_reset), .input_value(val8), .mode(1'b0),
    .start_timer(start8), .enable(enable), .hold(1'b0), .abort(abort),
`ifdef TIMER_EXTEND_EN
    .extend(1'b0), .extend_value(8'd0),
`endif
    .expired(exp8), .divider_reset(dr8), .busy(busy8), .remaining(rem8));

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  // monitor: any pulse, or any due expectation, consumes one scoreboard entry
  always @(negedge clk) begin
    if (expired || divider_reset || (sb.size() > 0 && sb[0].cyc <= pc)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: cyc %0d expired=%b divider_reset=%b, expected none", pc, expired, divider_reset);
      end else begin
        ev_t x;
        x = sb.pop_front();
        if (x.cyc != pc || x.e !== expired || x.d !== divider_reset) begin
          failures++;
          $display("FAIL pulse: cyc %0d expired=%b divider_reset=%b, expected cyc %0d expired=%b divider_reset=%b",
                   pc, expired, divider_reset, x.cyc, x.e, x.d);
        end
      end
    end
  end

  task automatic clk1(input logic en, input logic e, input logic d);
    enable = en;
    if (e || d) sb.push_back('{pc + 1, e, d});
    @(posedge clk);
    @(negedge clk);
    start_timer = 0;
    start8 = 0;
    abort = 0;
    enable = 0;
  endtask

  task automatic start(input logic [3:0] v, input logic m, input logic en, input logic e);
    input_value = v;
    mode = m;
    start_timer = 1;
    clk1(en, e, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_expired", expired, 0);
    chk("rst_divider_reset", divider_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_remaining", remaining, 0);
    sys_reset = 0;
    // asynchronous reset in the middle of a run
    start(5, 0, 0, 0);
    chk("run_busy", busy, 1);
    chk("run_remaining", remaining, 5);
    clk1(0, 0, 0);
    #2 sys_reset = 1;
    #1;
    chk("async_rst_remaining", remaining, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_expired", expired, 0);
    chk("async_rst_divider_reset", divider_reset, 0);
    @(negedge clk);
    sys_reset = 0;
    // one-shot, value 2, tick every 4th cycle
    start(2, 0, 0, 0);
    chk("os_load", remaining, 2);
    repeat (3) clk1(0, 0, 0);
    clk1(1, 0, 0);
    chk("os_tick1", remaining, 1);
    chk("os_busy1", busy, 1);
    repeat (3) clk1(0, 0, 0);
    clk1(1, 1, 0);
    chk("os_tick2", remaining, 0);
    chk("os_busy_drop", busy, 0);
    clk1(0, 0, 0);
    // periodic, value 3, tick every 2 cycles, 10 ticks
    start(3, 1, 0, 0);
    for (int t = 1; t <= 10; t++) begin
      clk1(0, 0, 0);
      clk1(1, t % 3 == 0, 0);
      chk($sformatf("per_rem_t%0d", t), remaining, t % 3 == 0 ? 3 : 3 - t % 3);
    end
    chk("per_busy", busy, 1);
    abort = 1;
    clk1(0, 0, 0);
    chk("per_abort_busy", busy, 0);
    chk("per_abort_rem", remaining, 0);
    // hold and abort
    start(4, 0, 0, 0);
    hold = 1;
    clk1(1, 0, 0);
    clk1(1, 0, 0);
    chk("hold_rem", remaining, 4);
    hold = 0;
    clk1(1, 0, 0);
    chk("release_rem", remaining, 3);
    abort = 1;
    input_value = 9;
    start_timer = 1;
    clk1(1, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rem", remaining, 0);
    clk1(0, 0, 0);
    // zero-length start, both modes
    start(0, 0, 0, 1);
    chk("zero_busy", busy, 0);
    chk("zero_rem", remaining, 0);
    start(0, 1, 1, 1);
    chk("zero_per_busy", busy, 0);
    // restart at remaining=1 with a coincident tick
    start(2, 0, 0, 0);
    clk1(1, 0, 0);
    chk("pre_restart_rem", remaining, 1);
    start(6, 0, 1, 0);
    chk("restart_rem", remaining, 6);
    chk("restart_busy", busy, 1);
    abort = 1;
    clk1(0, 0, 0);
`ifdef TIMER_EXTEND_EN
    start(14, 0, 0, 0);
    ext = 1;
    ext_val = 5;
    clk1(0, 0, 0);
    ext = 0;
    chk("ext_saturate", remaining, 15);
    abort = 1;
    clk1(0, 0, 0);
    start(1, 0, 0, 0);
    ext = 1;
    ext_val = 2;
    clk1(1, 0, 0);
    ext = 0;
    chk("ext_final_rem", remaining, 2);
    chk("ext_final_busy", busy, 1);
    abort = 1;
    clk1(0, 0, 0);
`endif
    // WIDTH=8, value 255 expires after exactly 255 ticks
    val8 = 255;
    start8 = 1;
    clk1(0, 0, 0);
    chk("w8_load", rem8, 255);
    chk("w8_dr", dr8, 1);
    repeat (254) clk1(1, 0, 0);
    chk("w8_rem254", rem8, 1);
    chk("w8_not_yet", exp8, 0);
    clk1(1, 0, 0);
    chk("w8_expired", exp8, 1);
    chk("w8_busy", busy8, 0);
    clk1(0, 0, 0);
    chk("w8_pulse_end", exp8, 0);
    repeat (2) clk1(0, 0, 0);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Parametrised successor to the traffic controller's phase timer. Counts down a loaded value in units of external tick pulses (`enable`, from the clock divider) and reports expiry.
- Adds the following over the phase timer:
  - configurable width
  - one-shot / periodic mode
  - hold (freeze)
  - abort
  - remaining-count and busy visibility
- Sits between the phase FSM (which drives start/value/mode) and the clock divider (which provides `enable` and receives `divider_reset`).

Parameters:
- WIDTH, 4, bit width of `input_value`, the internal count and `remaining`; legal range 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- sys_reset  input  1  asynchronous, active-high reset.
- input_value  input  WIDTH  duration in ticks; sampled only when `start_timer`=1.
- mode  input  1  0 = one-shot, 1 = periodic; sampled with `start_timer`.
- start_timer  input  1  single-cycle load/start request.
- enable  input  1  tick strobe from divider; one decrement per high cycle.
- hold  input  1  level; freezes the count while high.
- abort  input  1  single-cycle cancel.
- expired  output  1  registered, one-cycle pulse on expiry.
- divider_reset  output  1  registered, one-cycle pulse requesting divider phase realignment.
- busy  output  1  high when state != IDLE.
- remaining  output  WIDTH  current count (registered).

Behaviour:
- Reset (async, sys_reset=1): state=IDLE, count=0, reload=0, mode_q=0; expired=0, divider_reset=0, busy=0, remaining=0.
- States: IDLE, RUN. `busy` is a combinational decode of the state register.
- Priority per cycle: abort > start_timer > tick.
- abort=1 (any state):
  - next state IDLE, count=0.
  - No expired pulse; divider_reset=0.
  - Overrides a same-cycle start_timer or tick.
- start_timer=1 (no abort):
  - count <= input_value, reload <= input_value, mode_q <= mode.
  - divider_reset=1 on the next cycle; state <= RUN.
  - Legal in RUN (restart). A coincident tick is ignored.
- start with input_value=0: state stays/returns IDLE, expired=1 on the next cycle, divider_reset=1 on the next cycle. Applies in periodic mode too (no zero-length period).
- Tick = RUN & enable & ~hold.
  - count > 1: count <= count-1.
  - count == 1:
    - one-shot: count <= 0, state <= IDLE.
    - periodic: count <= reload, stay RUN; divider_reset NOT asserted (tick phase continues).
    - expired=1 on the next cycle in both modes.
- enable in IDLE, or while hold=1, is ignored; count is unchanged.
- Latency: expired rises exactly one clk after the edge at which the final tick is sampled. It is never high two consecutive cycles unless a periodic reload of 1 ticks every cycle.
- Arithmetic is unsigned WIDTH-bit. No underflow is possible because count 0 is only resident in IDLE.
- `remaining` mirrors the count register (reset 0, 0 after expiry in one-shot).
- Input changes other than on a start cycle do not affect `reload` or `mode_q`.

Optional Feature:
- Macro: TIMER_EXTEND_EN.
- Defined: adds ports `extend` (input, 1) and `extend_value` (input, WIDTH).
  - RUN & extend & no abort/start: count <= sat(count + extend_value - tick), saturating at 2^WIDTH-1.
  - A coincident final tick with extend_value >= 1 suppresses expiry and stays RUN.
  - reload is unaffected.
  - extend is ignored in IDLE.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset mid-RUN: WIDTH=4, start value 5, assert sys_reset asynchronously between edges -> all outputs 0 immediately, busy=0.
- One-shot, value 2, enable pulsed every 4th cycle:
  - divider_reset=1 the cycle after start.
  - remaining 2->1->0.
  - expired one-cycle pulse one clk after the 2nd tick; busy drops with it.
- Periodic, value 3, tick every 2 cycles for 10 ticks:
  - expired after ticks 3, 6, 9.
  - remaining reloads to 3; divider_reset only once, after start.
- Hold and abort, value 4:
  - hold high across 2 ticks -> remaining stays 4.
  - Release, 1 tick -> 3.
  - abort coincident with start_timer and tick -> IDLE, remaining 0, no expired, no divider_reset.
- Boundaries:
  - start value 0 -> expired and divider_reset pulse next cycle, busy stays 0.
  - Restart at remaining=1 coincident with a tick -> no expired, remaining = new value.
  - WIDTH=8, value 255 -> expires after exactly 255 ticks.
- TIMER_EXTEND_EN, WIDTH=4:
  - remaining 14, extend_value 5 -> 15 (saturated).
  - remaining 1 + tick + extend_value 2 -> remaining 2, no expired.
